// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and a
// constant-foldable clog2 used to size counters from parameters.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
   localparam logic [2:0] ST_START_ENC = 3'd1;
   localparam logic [2:0] ST_DATA_ENC  = 3'd2;
   localparam logic [2:0] ST_PAR_ENC   = 3'd3;
   localparam logic [2:0] ST_STOP_ENC  = 3'd4;
   localparam logic [2:0] ST_DONE_ENC  = 3'd5;
   localparam logic [2:0] ST_BREAK_ENC = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_START = ST_START_ENC,
      ST_DATA  = ST_DATA_ENC,
      ST_PAR   = ST_PAR_ENC,
      ST_STOP  = ST_STOP_ENC,
      ST_DONE  = ST_DONE_ENC,
      ST_BREAK = ST_BREAK_ENC
   } rx_state_t;

   // Bits needed to hold values 0..value-1; never less than 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input. The reset
// value is a parameter so idle-high lines do not glitch out of reset.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync
);

   logic meta;

   // Shift the async input through two flops to settle metastability.
   // NOTE: non-blocking assignments make both flops sample the old values at
   // the same edge; blocking here would collapse the chain into one flop.
   always_ff @(posedge i_Clock) begin
      if (i_reset) begin
         meta   <= RESET_VAL;
         o_sync <= RESET_VAL;
      end else begin
         meta   <= i_async;
         o_sync <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start detection, mid-bit sampling,
// 5..9 data bits, optional odd/even parity, 1 or 2 stop bits, break hold-off.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int OVS       = 16,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_reset,
   input  logic                 i_Rx_Serial,
   input  logic                 i_tick,
   output logic                 o_Rx_Done,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Busy
);

   localparam int TW = clog2(OVS);
   localparam int BW = clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] T_HALF      = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] T_LAST      = TW'(OVS - 1);
   localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic          HAS_PAR     = (PARITY != PAR_NONE);
   localparam logic          PAR_EXPECT  = (PARITY == PAR_ODD);

   rx_state_t             state;
   logic [TW-1:0]         tcnt;
   logic [BW-1:0]         bcnt;
   logic [DATA_BITS-1:0]  shreg;
   logic                  par_pend;
   logic                  frame_pend;
   logic                  rx_s;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .i_Clock (i_Clock),
      .i_reset (i_reset),
      .i_async (i_Rx_Serial),
      .o_sync  (rx_s)
   );

   // Receive FSM with its counters, shift register, pending flags and
   // registered outputs; reset wins over every other event.
   // NOTE: the shift register is reset along with the control state so a
   // reset mid-frame can never leak partial data into a later o_Rx_Byte.
   always_ff @(posedge i_Clock) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         tcnt         <= '0;
         bcnt         <= '0;
         shreg        <= '0;
         par_pend     <= 1'b0;
         frame_pend   <= 1'b0;
         o_Rx_Done    <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         o_Rx_Done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state      <= ST_START;
                  tcnt       <= '0;
                  par_pend   <= 1'b0;
                  frame_pend <= 1'b0;
                  o_Busy     <= 1'b1;
               end
            end
            ST_START: begin
               if (i_tick) begin
                  if (tcnt == T_HALF) begin
                     tcnt <= '0;
                     if (!rx_s) begin
                        state <= ST_DATA;
                        bcnt  <= '0;
                     end else begin
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (i_tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt  <= '0;
                     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                     if (bcnt == B_LAST_DATA) begin
                        bcnt  <= '0;
                        state <= HAS_PAR ? ST_PAR : ST_STOP;
                     end else begin
                        bcnt <= bcnt + 1'b1;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_PAR: begin
               if (i_tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt     <= '0;
                     par_pend <= ((^shreg ^ rx_s) != PAR_EXPECT);
                     state    <= ST_STOP;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (i_tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt <= '0;
                     if (!rx_s) frame_pend <= 1'b1;
                     if (bcnt == B_LAST_STOP) begin
                        bcnt  <= '0;
                        state <= ST_DONE;
                     end else begin
                        bcnt <= bcnt + 1'b1;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               o_Rx_Done    <= 1'b1;
               o_Rx_Byte    <= shreg;
               o_Parity_Err <= HAS_PAR && par_pend;
               o_Frame_Err  <= frame_pend;
               o_Busy       <= 1'b0;
               state        <= (frame_pend && !rx_s) ? ST_BREAK : ST_IDLE;
            end
            ST_BREAK: begin
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next-generation replacement for the fixed 8N1 receiver in the UART path. It samples the serial line at `OVS` ticks per bit and samples mid-bit. It supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. Each received character is delivered as a parallel word with a one-cycle done strobe plus parity/framing error flags. It sits between the pad-side serial input and the receive FIFO / interface logic, and is fed by the shared baud-tick generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `OVS`, default 16: `i_tick` pulses per bit period, even, legal 8..32.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `i_Clock`, in, 1: system clock; all logic on rising edge.
- `i_reset`, in, 1: synchronous, active-high reset. Reset is `i_reset`, synchronous, active-high; clock is `i_Clock`.
- `i_Rx_Serial`, in, 1: asynchronous serial line, idle high.
- `i_tick`, in, 1: oversampling tick, one-cycle pulse, `OVS` pulses per bit.
- `o_Rx_Done`, out, 1: one-cycle strobe; the frame is complete and outputs are valid.
- `o_Rx_Byte`, out, DATA_BITS: received data, LSB = first bit on the wire.
- `o_Parity_Err`, out, 1: parity mismatch on the last frame; always 0 when `PARITY` = 0.
- `o_Frame_Err`, out, 1: a stop bit sampled low on the last frame.
- `o_Busy`, out, 1: high from start-bit detect until the DONE state exits.

## Operation
- **Input synchronisation:** `i_Rx_Serial` passes through a 2-FF synchroniser (reset value 1). All decisions use the synchronised value `rx_s`.
- **States:** IDLE, START, DATA, PAR, STOP, DONE, BREAK. Tick counter `tcnt` has width clog2(OVS); bit counter `bcnt` has width clog2(DATA_BITS+1).
- **IDLE:**
  - `rx_s` = 0 → START, with `tcnt` = 0.
  - Otherwise stay in IDLE.
- **START:** on each tick, `tcnt`++. At the tick where `tcnt` = OVS/2−1:
  - `rx_s` = 0 → DATA, with `tcnt` = 0 and `bcnt` = 0. The sample point is now mid-bit.
  - `rx_s` = 1 → IDLE. This is glitch rejection: no done strobe, no flag change.
- **DATA:** at the tick where `tcnt` = OVS−1:
  - Shift `rx_s` into the MSB of the shift register (right shift), `tcnt` = 0, `bcnt`++.
  - After the DATA_BITS-th sample → PAR if `PARITY` ≠ 0, else STOP.
- **PAR:** at `tcnt` = OVS−1, sample the parity bit.
  - Error = (^data ^ sample) ≠ expected, where expected is 1 for odd and 0 for even.
  - Then → STOP.
- **STOP:** at `tcnt` = OVS−1, sample each stop bit.
  - Any low sample sets a pending framing error.
  - After `STOP_BITS` samples → DONE.
- **DONE:** one cycle. Assert `o_Rx_Done`; load `o_Rx_Byte`, `o_Parity_Err` and `o_Frame_Err` from the shift register and pending flags.
  - Framing error and `rx_s` = 0 → BREAK.
  - Otherwise → IDLE.
- **BREAK:** wait until `rx_s` = 1, then → IDLE. No start detection happens while in BREAK.
- Outputs hold their value between DONE strobes. A frame with errors is still delivered, with its flags set.
- `i_tick` is ignored in IDLE, DONE and BREAK. Counters advance only on `i_tick`.

## Timing
- **Reset values:**
  - `o_Rx_Done` = 0, `o_Rx_Byte` = 0, `o_Parity_Err` = 0, `o_Frame_Err` = 0, `o_Busy` = 0.
  - State = IDLE, synchroniser = 1, counters = 0.
- **Reset mid-frame:** the next cycle is IDLE with all outputs at reset values and no done strobe. Reset has priority over all other events.
- **Start-detect latency:** 2 cycles from the line falling to `rx_s` = 0, plus 1 cycle to enter START. `o_Busy` rises on that transition.
- **Done latency:** `o_Rx_Done` is high exactly 1 cycle after the clock edge that registers the tick sampling the last stop bit. It drops the following cycle.
- **Back-to-back frames:** a start bit arriving immediately after the stop bit is detected, since DONE lasts one cycle, which is far shorter than OVS/2 ticks.
- **Tick in DONE:** an `i_tick` coincident with DONE is dropped. This is harmless because it is ≤ 1/OVS of a bit.

## Structure
- **Shared package `uart_pkg`:**
  - Parity constants `PAR_NONE` = 0, `PAR_ODD` = 1, `PAR_EVEN` = 2.
  - Receiver state encoding (3-bit localparams).
  - `clog2` helper function.
  - The future transmitter reuses the same package.
- **Sub-module `uart_sync2`:** 2-FF synchroniser with a parameterised reset value. It is instantiated once here and reused by other async inputs.
- Everything else (FSM, counters, shift register, parity accumulator) lives in one module.

## Test plan
Benches use `i_tick` every 4 clocks unless stated otherwise.

- **8N1, OVS 16, byte 0xA5** → one `o_Rx_Done` pulse, `o_Rx_Byte` = 0xA5, both error flags 0, `o_Busy` low after DONE.
- **7E1 (DATA_BITS 7, PARITY 2):**
  - Send 0x35 with a correct parity bit (0) → `o_Rx_Byte` = 0x35, `o_Parity_Err` = 0.
  - Repeat with the parity bit inverted → same data, `o_Parity_Err` = 1.
- **8N2, byte 0x3C, second stop bit driven low** → Done with `o_Rx_Byte` = 0x3C, `o_Frame_Err` = 1.
  - Then hold the line low for 3 bit-times → FSM stays in BREAK, no further Done.
  - Release the line, then send 0x81 → Done with 0x81, `o_Frame_Err` = 0.
- **Line low pulse of 5 ticks (< OVS/2)** → no Done, `o_Busy` returns to 0, outputs unchanged from the previous frame.
- **`i_reset` asserted in the middle of DATA for byte 0xFF** → next cycle all outputs are 0 with no Done. A subsequent 0x5A frame is received correctly.
- **Two frames back-to-back (0x00 then 0xFF), 9N1 with `i_tick` every cycle** → two Done pulses with `o_Rx_Byte` = 0x000 then 0x1FF, no error flags.
